// File: rtl/pipeline_controller_if.sv
// rtl/pipeline_controller_if.sv - decode/hazard/forwarding control bundle between datapath and controller
interface pipeline_controller_if;
    logic [31:0] instr_D;
    logic        breq_flag;
    logic        brlt_flag;
    logic        bge_flag;
    logic [4:0]  read_reg_r1;
    logic [4:0]  read_reg_r2;
    logic [11:0] read_imm_12;
    logic [1:0]  imm_sel;
    logic [3:0]  alu_select;
    logic        asel;
    logic        bsel;
    logic        brun_en;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        dm_write_en;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [1:0]  wbsel;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        pc_sel;

    modport master (
        output instr_D, breq_flag, brlt_flag, bge_flag,
        input  read_reg_r1, read_reg_r2, read_imm_12, imm_sel,
        input  alu_select, asel, bsel, brun_en, ForwardAE, ForwardBE,
        input  dm_write_en, reg_write_en, reg_write_dest, wbsel,
        input  stallF, stallD, flushD, flushE, pc_sel
    );

    modport slave (
        input  instr_D, breq_flag, brlt_flag, bge_flag,
        output read_reg_r1, read_reg_r2, read_imm_12, imm_sel,
        output alu_select, asel, bsel, brun_en, ForwardAE, ForwardBE,
        output dm_write_en, reg_write_en, reg_write_dest, wbsel,
        output stallF, stallD, flushD, flushE, pc_sel
    );
endinterface

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - five-stage RV32 subset controller: decode, D/E/M/W control pipe, forwarding and hazards
module pipeline_controller (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_controller_if.slave bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [3:0] alu;
        logic       asel;
        logic       bsel;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] wbsel;
        logic       is_branch;
        logic       is_jalr;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ctl_e;
    logic       reads_rs2;
    logic [1:0] imm_sel_d;

    logic       m_regwrite;
    logic       m_memwrite;
    logic [1:0] m_wbsel;
    logic [4:0] m_rd;
    logic       w_regwrite;
    logic [1:0] w_wbsel;
    logic [4:0] w_rd;

    logic       load_use;
    logic       br_taken;
    logic       redirect;

    // funct7[5] (instr[30]) picks sub for R-type only and sra for both R and I shifts.
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_r && alt) ? 4'b0001 : 4'b0000;
            3'b001:  code = 4'b0010;
            3'b010:  code = 4'b0011;
            3'b011:  code = 4'b0100;
            3'b100:  code = 4'b0101;
            3'b101:  code = alt ? 4'b0111 : 4'b0110;
            3'b110:  code = 4'b1000;
            default: code = 4'b1001;
        endcase
        return code;
    endfunction

    always_comb begin
        dec        = '0;
        reads_rs2  = 1'b0;
        imm_sel_d  = 2'b00;
        dec.rs1    = bus.instr_D[19:15];
        dec.rs2    = bus.instr_D[24:20];
        dec.funct3 = bus.instr_D[14:12];
        case (bus.instr_D[6:0])
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.wbsel    = 2'b01;
                dec.rd       = bus.instr_D[11:7];
                dec.alu      = alu_code(bus.instr_D[14:12], bus.instr_D[30], 1'b1);
                reads_rs2    = 1'b1;
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.wbsel    = 2'b01;
                dec.rd       = bus.instr_D[11:7];
                dec.bsel     = 1'b1;
                dec.alu      = alu_code(bus.instr_D[14:12], bus.instr_D[30], 1'b0);
            end
            OP_LW: begin
                dec.regwrite = 1'b1;
                dec.rd       = bus.instr_D[11:7];
                dec.bsel     = 1'b1;
            end
            OP_SW: begin
                dec.memwrite = 1'b1;
                dec.bsel     = 1'b1;
                reads_rs2    = 1'b1;
                imm_sel_d    = 2'b01;
            end
            OP_BR: begin
                if (bus.instr_D[14:13] != 2'b01) begin
                    dec.is_branch = 1'b1;
                    dec.asel      = 1'b1;
                    dec.bsel      = 1'b1;
                    reads_rs2     = 1'b1;
                    imm_sel_d     = 2'b10;
                end
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.wbsel    = 2'b10;
                dec.rd       = bus.instr_D[11:7];
                dec.bsel     = 1'b1;
                dec.is_jalr  = 1'b1;
            end
            default: ;
        endcase
        if (dec.rd == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    always_comb begin
        case (imm_sel_d)
            2'b01:   bus.read_imm_12 = {bus.instr_D[31:25], bus.instr_D[11:7]};
            2'b10:   bus.read_imm_12 = {bus.instr_D[31], bus.instr_D[7], bus.instr_D[30:25], bus.instr_D[11:8]};
            default: bus.read_imm_12 = bus.instr_D[31:20];
        endcase
    end

    always_comb begin
        case (ctl_e.funct3)
            3'b000:         br_taken = bus.breq_flag;
            3'b001:         br_taken = ~bus.breq_flag;
            3'b100, 3'b110: br_taken = bus.brlt_flag;
            default:        br_taken = bus.bge_flag;
        endcase
    end

    // Only a load in EX (wbsel 00 with a real destination) can create a use hazard.
    assign load_use = ctl_e.regwrite && (ctl_e.wbsel == 2'b00) && (ctl_e.rd != 5'd0) &&
                      ((ctl_e.rd == dec.rs1) || (reads_rs2 && (ctl_e.rd == dec.rs2)));
    assign redirect = ctl_e.is_jalr || (ctl_e.is_branch && br_taken);

    always_comb begin
        bus.ForwardAE = 2'b00;
        if (ctl_e.rs1 != 5'd0 && m_regwrite && ctl_e.rs1 == m_rd) begin
            bus.ForwardAE = 2'b10;
        end else if (ctl_e.rs1 != 5'd0 && w_regwrite && ctl_e.rs1 == w_rd) begin
            bus.ForwardAE = 2'b01;
        end
        bus.ForwardBE = 2'b00;
        if (ctl_e.rs2 != 5'd0 && m_regwrite && ctl_e.rs2 == m_rd) begin
            bus.ForwardBE = 2'b10;
        end else if (ctl_e.rs2 != 5'd0 && w_regwrite && ctl_e.rs2 == w_rd) begin
            bus.ForwardBE = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_e      <= '0;
            m_regwrite <= 1'b0;
            m_memwrite <= 1'b0;
            m_wbsel    <= 2'b00;
            m_rd       <= 5'd0;
            w_regwrite <= 1'b0;
            w_wbsel    <= 2'b00;
            w_rd       <= 5'd0;
        end else begin
            if (redirect || load_use) begin
                ctl_e <= '0;
            end else begin
                ctl_e <= dec;
            end
            m_regwrite <= ctl_e.regwrite;
            m_memwrite <= ctl_e.memwrite;
            m_wbsel    <= ctl_e.wbsel;
            m_rd       <= ctl_e.rd;
            w_regwrite <= m_regwrite;
            w_wbsel    <= m_wbsel;
            w_rd       <= m_rd;
        end
    end

    assign bus.read_reg_r1    = bus.instr_D[19:15];
    assign bus.read_reg_r2    = bus.instr_D[24:20];
    assign bus.imm_sel        = imm_sel_d;
    assign bus.alu_select     = ctl_e.alu;
    assign bus.asel           = ctl_e.asel;
    assign bus.bsel           = ctl_e.bsel;
    assign bus.brun_en        = ctl_e.is_branch && (ctl_e.funct3[2:1] == 2'b11);
    assign bus.dm_write_en    = m_memwrite;
    assign bus.reg_write_en   = w_regwrite;
    assign bus.reg_write_dest = w_rd;
    assign bus.wbsel          = w_wbsel;
    assign bus.pc_sel         = redirect;
    assign bus.flushD         = redirect;
    assign bus.flushE         = redirect || load_use;
    assign bus.stallF         = load_use && !redirect;
    assign bus.stallD         = load_use && !redirect;
endmodule
